// File: rtl/sl_pkg.sv
// Shared types and constants for the two-wire SL receiver.
package sl_pkg;

    localparam int   SL_DW       = 32;
    localparam logic SL_IDLE_LVL = 1'b1;

    localparam int WLC = 0;
    localparam int PEF = 1;
    localparam int LEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SAMPLE    = 3'd1,
        ST_WAIT_END  = 3'd2,
        ST_GAP       = 3'd3,
        ST_LEVEL_ERR = 3'd4
    } sl_state_e;

    typedef struct packed {
        logic [2:0]       status;
        logic [SL_DW-1:0] data;
    } sl_entry_t;

    // 0 means one bit; anything past the data width saturates to it
    function automatic logic [5:0] sl_clamp_len(input logic [5:0] len, input logic [5:0] max_len);
        if (len == 6'd0)   return 6'd1;
        if (len > max_len) return max_len;
        return len;
    endfunction

endpackage

// File: rtl/sl_sync_fifo.sv
// Synchronous FIFO with valid/ready read port; head is read combinationally.
module sl_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    output logic                     full,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         pop, wr_en;

    assign level    = wr_ptr - rd_ptr;
    assign full     = (level == (AW+1)'(DEPTH));
    assign rd_valid = (level != '0);
    assign rd_data  = mem[rd_ptr[AW-1:0]];
    assign pop      = rd_valid & rd_ready;
    // a pop frees the slot the write lands in, so a full FIFO still accepts
    assign wr_en    = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/sl_rx_fifo_receiver.sv
// Two-wire SL receiver: decodes frames into a status-tagged word FIFO.
// Define SL_RX_GLITCH_FILTER_EN to add a 3-sample majority filter per line.
module sl_rx_fifo_receiver
    import sl_pkg::*;
#(
    parameter int MAX_BITS    = 32,
    parameter int STROB_POS   = 8,
    parameter int END_SAMPLES = 4,
    parameter int BIT_TIMEOUT = 64,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          serial_line_zeroes_a,
    input  logic                          serial_line_ones_a,
    input  logic [5:0]                    cfg_len,
    input  logic                          cfg_pce,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [MAX_BITS-1:0]           rd_data,
    output logic [2:0]                    rd_status,
    output logic                          busy,
    output logic                          ovf,
    input  logic                          ovf_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int CMAX = (BIT_TIMEOUT > STROB_POS) ? BIT_TIMEOUT : STROB_POS;
    localparam int CW   = $clog2(CMAX + 1) + 1;
    localparam int EW   = $clog2(END_SAMPLES + 1);

    logic [1:0] z_sync, o_sync;
    logic       z, o, z_d, o_d, start;

    always_ff @(posedge clk) begin
        if (rst) begin
            z_sync <= {2{SL_IDLE_LVL}};
            o_sync <= {2{SL_IDLE_LVL}};
        end else begin
            z_sync <= {z_sync[0], serial_line_zeroes_a};
            o_sync <= {o_sync[0], serial_line_ones_a};
        end
    end

`ifdef SL_RX_GLITCH_FILTER_EN
    logic [1:0] z_h, o_h;
    always_ff @(posedge clk) begin
        if (rst) begin
            z_h <= {2{SL_IDLE_LVL}};
            o_h <= {2{SL_IDLE_LVL}};
            z   <= SL_IDLE_LVL;
            o   <= SL_IDLE_LVL;
        end else begin
            z_h <= {z_h[0], z_sync[1]};
            o_h <= {o_h[0], o_sync[1]};
            z   <= (z_sync[1] & z_h[0]) | (z_sync[1] & z_h[1]) | (z_h[0] & z_h[1]);
            o   <= (o_sync[1] & o_h[0]) | (o_sync[1] & o_h[1]) | (o_h[0] & o_h[1]);
        end
    end
`else
    assign z = z_sync[1];
    assign o = o_sync[1];
`endif

    assign start = (z_d & ~z) | (o_d & ~o);

    sl_state_e          state;
    logic [CW-1:0]      cyc;
    logic [EW-1:0]      end_cnt;
    logic [5:0]         bit_cnt, len_r;
    logic               pce_r, par_acc, busy_r, to_en;
    logic [MAX_BITS-1:0] data_r, mask;
    logic               push_vld;
    sl_entry_t          push_ent, stop_ent, rd_ent;
    logic [6:0]         exp_cnt;

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_BITS; i++) mask[i] = (6'(i) < len_r);
    end

    // parity bit sits at position len and is dropped by the mask
    assign exp_cnt = {1'b0, len_r} + {6'd0, pce_r};
    always_comb begin
        stop_ent = '0;
        if ({1'b0, bit_cnt} != exp_cnt)   stop_ent.status[WLC] = 1'b1;
        else if (pce_r && !par_acc)       stop_ent.status[PEF] = 1'b1;
        else                              stop_ent.data[MAX_BITS-1:0] = data_r & mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            z_d      <= SL_IDLE_LVL;
            o_d      <= SL_IDLE_LVL;
            cyc      <= '0;
            end_cnt  <= '0;
            bit_cnt  <= '0;
            len_r    <= 6'd1;
            pce_r    <= 1'b0;
            par_acc  <= 1'b0;
            data_r   <= '0;
            busy_r   <= 1'b0;
            to_en    <= 1'b0;
            push_vld <= 1'b0;
            push_ent <= '0;
        end else begin
            push_vld <= 1'b0;
            z_d      <= z;
            o_d      <= o;
            case (state)
                ST_IDLE, ST_GAP: if (start) begin
                    state <= ST_SAMPLE;
                    cyc   <= CW'(1);
                    if (state == ST_IDLE) begin
                        len_r   <= sl_clamp_len(cfg_len, 6'(MAX_BITS));
                        pce_r   <= cfg_pce;
                        bit_cnt <= '0;
                        par_acc <= 1'b0;
                        data_r  <= '0;
                        busy_r  <= 1'b1;
                        to_en   <= 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    cyc <= cyc + CW'(1);
                    if (cyc == CW'(STROB_POS)) begin
                        end_cnt <= '0;
                        state   <= ST_WAIT_END;
                        case ({z, o})
                            2'b10: begin
                                for (int i = 0; i < MAX_BITS; i++)
                                    if (bit_cnt == 6'(i)) data_r[i] <= 1'b1;
                                bit_cnt <= (bit_cnt == 6'd63) ? bit_cnt : bit_cnt + 6'd1;
                                par_acc <= ~par_acc;
                            end
                            2'b01: bit_cnt <= (bit_cnt == 6'd63) ? bit_cnt : bit_cnt + 6'd1;
                            2'b00: begin
                                push_vld <= 1'b1;
                                push_ent <= stop_ent;
                                busy_r   <= 1'b0;
                                to_en    <= 1'b0;
                            end
                            default: state <= ST_LEVEL_ERR;
                        endcase
                    end
                end
                ST_WAIT_END: begin
                    cyc <= cyc + CW'(1);
                    if (to_en && cyc >= CW'(BIT_TIMEOUT)) begin
                        state <= ST_LEVEL_ERR;
                    end else if (z & o) begin
                        end_cnt <= end_cnt + EW'(1);
                        // a finished or aborted frame re-arms config latching
                        if (end_cnt == EW'(END_SAMPLES - 1)) state <= busy_r ? ST_GAP : ST_IDLE;
                    end else begin
                        end_cnt <= '0;
                    end
                end
                ST_LEVEL_ERR: begin
                    push_vld        <= 1'b1;
                    push_ent        <= '0;
                    push_ent.status <= 3'b100;
                    busy_r          <= 1'b0;
                    to_en           <= 1'b0;
                    bit_cnt         <= '0;
                    par_acc         <= 1'b0;
                    data_r          <= '0;
                    end_cnt         <= '0;
                    state           <= ST_WAIT_END;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic fifo_full;

    sl_sync_fifo #(.W($bits(sl_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_vld),
        .push_data (push_ent),
        .full      (fifo_full),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_ent),
        .level     (fifo_level)
    );

    assign rd_data   = rd_ent.data[MAX_BITS-1:0];
    assign rd_status = rd_ent.status;
    assign busy      = busy_r;

    always_ff @(posedge clk) begin
        if (rst)                                        ovf <= 1'b0;
        else if (push_vld && fifo_full && !(rd_valid && rd_ready)) ovf <= 1'b1;
        else if (ovf_clr)                               ovf <= 1'b0;
    end

endmodule

// File: doc/sl_rx_fifo_receiver.md
Name: sl_rx_fifo_receiver

Overview:
- Parametrised second-generation two-wire SL receiver.
- Decodes bits on the zeroes/ones line pair into words of run-time length 1..MAX_BITS, with optional odd-parity check.
- Queues every finished frame (good or errored) together with its status flags in a word FIFO, read through a valid/ready port.
- Sits between the SL pads and the register/bus interface; replaces the single-buffer receiver.

Parameters:
- MAX_BITS, 32, maximum data bits per word (1..32); sets data width.
- STROB_POS, 8, cycles after bit start at which line levels are sampled.
- END_SAMPLES, 4, consecutive both-high samples that end a bit.
- BIT_TIMEOUT, 64, cycles after bit start without bit end before a level error.
- FIFO_DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock (16 MHz nominal).
- rst  in  1  synchronous reset, active-high.
- serial_line_zeroes_a  in  1  async SL zeroes line; idle high.
- serial_line_ones_a  in  1  async SL ones line; idle high.
- cfg_len  in  6  data bits per word, 1..MAX_BITS; 0 is treated as 1, values above MAX_BITS as MAX_BITS.
- cfg_pce  in  1  parity check enable.
- rd_valid  out  1  FIFO head valid.
- rd_ready  in  1  consumer accepts head.
- rd_data  out  MAX_BITS  head word, LSB = first received bit.
- rd_status  out  3  head flags {LEF,PEF,WLC}.
- busy  out  1  frame reception in progress.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  clears ovf.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy.

Behaviour:
- Reset (sync, active-high): both input sync flops set to 1; FSM to IDLE; counters cleared; FIFO empty.
  - Output reset values: rd_valid=0, rd_data=0, rd_status=0, busy=0, ovf=0, fifo_level=0.
  - Reset mid-frame discards the partial word; nothing is pushed.
- Inputs pass through a 2-flop synchroniser. All decoding uses the synchronised levels z and o.
- Bit start: z or o falls from 1 to 0 while the FSM is in IDLE or GAP.
- FSM states and transitions:
  - IDLE: bit start → SAMPLE with cyc=1. Latch cfg_len and cfg_pce on the first bit of a frame; mid-frame config changes are ignored.
  - SAMPLE: cyc increments each cycle. At cyc==STROB_POS, decode:
    - z=1, o=0 → data one.
    - z=0, o=1 → data zero.
    - z=0, o=0 → stop.
    - z=1, o=1 → LEVEL_ERR.
  - Data bit: store at position bit_cnt; bit_cnt increments; toggle par_acc on a one. Bits beyond position MAX_BITS are counted but not stored; bit_cnt saturates at 63. Go to WAIT_END.
  - WAIT_END: END_SAMPLES consecutive z=o=1 → GAP. cyc reaching BIT_TIMEOUT → LEVEL_ERR.
  - GAP: bit start → SAMPLE with cyc=1.
  - Stop (from SAMPLE):
    - Expected bit count = len+1 when pce=1, len when pce=0.
    - bit_cnt ≠ expected → push WLC=1, data 0.
    - Else if pce=1 and par_acc=0 (odd parity over data and parity bit fails) → push PEF=1, data 0.
    - Else push data with bits ≥ len masked to 0 and the parity bit excluded.
    - Then WAIT_END.
  - LEVEL_ERR: push LEF=1, data 0, in one cycle. Then WAIT_END with the timeout disabled; frame state is cleared.
- busy=1 from the first bit start until the stop or error push.
- FIFO:
  - Push and pop in the same cycle are both performed; level is unchanged.
  - Push when full and no pop: entry dropped, ovf=1.
  - Pop only when rd_valid and rd_ready. rd_data and rd_status hold while rd_valid=1 and rd_ready=0.
  - Pushed entry is visible on rd_valid the cycle after the push (1-cycle latency from push).
  - ovf_clr together with a new overflow in the same cycle: ovf stays 1.
- Latency: stop sample → rd_valid high after 2 cycles when the FIFO was empty.

Optional Feature:
- SL_RX_GLITCH_FILTER_EN defined: a 3-sample majority filter follows the synchroniser on each line. Single-cycle glitches are rejected; decode latency increases by 2 cycles.
- Undefined: synchronised levels feed the FSM directly.

Decomposition:
- Package sl_pkg holds:
  - FSM state enum (IDLE, SAMPLE, WAIT_END, GAP, LEVEL_ERR).
  - Status bit indices WLC=0, PEF=1, LEF=2.
  - FIFO entry struct {status, data}.
  - Line idle level constant.
- Sub-module sl_sync_fifo: parametrised synchronous FIFO with valid/ready read, full/empty and level outputs.

Test Plan:
- Send 8 data bits plus parity for 0xA5, cfg_len=8, pce=1, correct parity → rd_valid with rd_data=0x000000A5, rd_status=000.
- Same frame with parity bit inverted → rd_status PEF=1, rd_data=0.
- cfg_len=8, pce=0, send 7 bits then stop → WLC=1. Send 32 bits with cfg_len=32, pce=0 → exact word received.
- Hold z=o=1 at STROB_POS after a start (start glitch), and separately hold one line low for 70 cycles → LEF entries; receiver then recovers on the next valid frame.
- Push 5 frames with rd_ready=0 and FIFO_DEPTH=4 → fifo_level=4, ovf=1, first 4 words preserved in order. Then ovf_clr → ovf=0.
- Assert rst mid-frame after 3 bits, then send a full frame → only the full frame appears. With SL_RX_GLITCH_FILTER_EN, a 1-cycle low pulse produces no bit start.
